// File: rtl/alu_decode_stage_pkg.sv
// Shared types and encodings for the RV32I ID->EX decode stage.
// Holds ALU opcodes, operand selects, RV32I opcode/funct fields and the decoded bundle.
package alu_decode_stage_pkg;

   localparam int unsigned WORD_WIDTH = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned ALU_CTL_W  = 4;
   localparam int unsigned A_SEL_W    = 2;

   typedef enum logic [ALU_CTL_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_EQ   = 4'd10,
      ALU_NEQ  = 4'd11,
      ALU_GE   = 4'd12,
      ALU_GEU  = 4'd13
   } alu_op_e;

   localparam logic [A_SEL_W-1:0] A_SEL_RS1  = 2'd0;
   localparam logic [A_SEL_W-1:0] A_SEL_PC   = 2'd1;
   localparam logic [A_SEL_W-1:0] A_SEL_ZERO = 2'd2;
   localparam logic               B_SEL_RS2  = 1'b0;
   localparam logic               B_SEL_IMM  = 1'b1;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   typedef struct packed {
      logic [ALU_CTL_W-1:0]  alu_ctl;
      logic [A_SEL_W-1:0]    a_sel;
      logic                  b_sel;
      logic [WORD_WIDTH-1:0] imm;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic                  is_branch;
      logic                  illegal;
      logic [WORD_WIDTH-1:0] pc;
   } dec_bundle_t;

   // Integer ALU op for OP/OP-IMM; alt picks SUB/SRA over ADD/SRL
   function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic f3_has_alt(input logic [2:0] f3);
      return (f3 == F3_ADD) || (f3 == F3_SR);
   endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Fetch-side and EX-side handshake plus decoded bundle of the decode stage.
// master = the decode stage, slave = its surroundings (fetch + execute).
interface alu_decode_stage_if;
   import alu_decode_stage_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [WORD_WIDTH-1:0] in_instr;
   logic [WORD_WIDTH-1:0] in_pc;
   logic                  flush;

   logic                  out_valid;
   logic                  out_ready;
   logic [ALU_CTL_W-1:0]  alu_ctl;
   logic [A_SEL_W-1:0]    a_sel;
   logic                  b_sel;
   logic [WORD_WIDTH-1:0] imm;
   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic [REG_ADDR_W-1:0] rd;
   logic                  is_branch;
   logic                  illegal;
   logic [WORD_WIDTH-1:0] pc_out;

   modport master (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, alu_ctl, a_sel, b_sel, imm,
             rs1, rs2, rd, is_branch, illegal, pc_out
   );

   modport slave (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, alu_ctl, a_sel, b_sel, imm,
             rs1, rs2, rd, is_branch, illegal, pc_out
   );

endinterface

// File: rtl/alu_decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction, format chosen from the opcode.
module alu_decode_stage_imm_gen
   import alu_decode_stage_pkg::*;
(
   input  logic [WORD_WIDTH-1:0] instr_i,
   output logic [WORD_WIDTH-1:0] imm_c_o
);

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [WORD_WIDTH-1:0] i_imm;
   logic [WORD_WIDTH-1:0] s_imm;
   logic [WORD_WIDTH-1:0] b_imm;
   logic [WORD_WIDTH-1:0] u_imm;
   logic [WORD_WIDTH-1:0] j_imm;
   logic [WORD_WIDTH-1:0] sh_imm;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];

   assign i_imm  = {{20{instr_i[31]}}, instr_i[31:20]};
   assign s_imm  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign b_imm  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
   assign u_imm  = {instr_i[31:12], 12'h000};
   assign j_imm  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
   assign sh_imm = {27'd0, instr_i[24:20]};

   always_comb begin : sel_format
      imm_c_o = '0;
      case (opcode)
         OPC_OP_IMM:         imm_c_o = ((funct3 == F3_SLL) || (funct3 == F3_SR)) ? sh_imm : i_imm;
         OPC_LOAD, OPC_JALR: imm_c_o = i_imm;
         OPC_STORE:          imm_c_o = s_imm;
         OPC_BRANCH:         imm_c_o = b_imm;
         OPC_LUI, OPC_AUIPC: imm_c_o = u_imm;
         OPC_JAL:            imm_c_o = j_imm;
         default:            imm_c_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ID->EX stage: decodes one RV32I instruction per accepted beat into
// an ALU control bundle held in a one-entry output register with valid/ready and flush.
module alu_decode_stage
   import alu_decode_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   alu_decode_stage_if.master bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e                state_q;
   state_e                state_d;
   dec_bundle_t           bundle_q;
   dec_bundle_t           bundle_d;
   dec_bundle_t           dec_c;
   logic [WORD_WIDTH-1:0] imm_c;
   logic                  bad_c;
   logic                  accept_c;
   logic                  consume_c;
   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;

   assign opcode = bus.in_instr[6:0];
   assign funct3 = bus.in_instr[14:12];
   assign funct7 = bus.in_instr[31:25];

   alu_decode_stage_imm_gen u_imm_gen (
      .instr_i (bus.in_instr),
      .imm_c_o (imm_c)
   );

   // Opcode decode; an illegal encoding still produces a bundle, neutralised below
   always_comb begin : decode
      dec_c     = '0;
      bad_c     = 1'b0;
      dec_c.imm = imm_c;
      dec_c.rs1 = bus.in_instr[19:15];
      dec_c.rs2 = bus.in_instr[24:20];
      dec_c.rd  = bus.in_instr[11:7];
      dec_c.pc  = bus.in_pc;
      case (opcode)
         OPC_OP: begin
            dec_c.alu_ctl = f3_to_alu(funct3, funct7[5]);
            bad_c = !((funct7 == F7_BASE) || ((funct7 == F7_ALT) && f3_has_alt(funct3)));
         end
         OPC_OP_IMM: begin
            dec_c.b_sel   = B_SEL_IMM;
            dec_c.alu_ctl = f3_to_alu(funct3, funct7[5] && (funct3 == F3_SR));
            if (funct3 == F3_SLL) begin
               bad_c = (funct7 != F7_BASE);
            end else if (funct3 == F3_SR) begin
               bad_c = (funct7 != F7_BASE) && (funct7 != F7_ALT);
            end
         end
         OPC_BRANCH: begin
            dec_c.is_branch = 1'b1;
            dec_c.rd        = '0;
            case (funct3)
               F3_BEQ:  dec_c.alu_ctl = ALU_EQ;
               F3_BNE:  dec_c.alu_ctl = ALU_NEQ;
               F3_BLT:  dec_c.alu_ctl = ALU_SLT;
               F3_BGE:  dec_c.alu_ctl = ALU_GE;
               F3_BLTU: dec_c.alu_ctl = ALU_SLTU;
               F3_BGEU: dec_c.alu_ctl = ALU_GEU;
               default: bad_c = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec_c.b_sel = B_SEL_IMM;
            bad_c = (funct3 == 3'b011) || (funct3 >= 3'b110);
         end
         OPC_STORE: begin
            dec_c.b_sel = B_SEL_IMM;
            dec_c.rd    = '0;
            bad_c = (funct3 > 3'b010);
         end
         OPC_JALR: begin
            dec_c.b_sel = B_SEL_IMM;
            bad_c = (funct3 != 3'b000);
         end
         OPC_LUI: begin
            dec_c.a_sel = A_SEL_ZERO;
            dec_c.b_sel = B_SEL_IMM;
         end
         OPC_AUIPC, OPC_JAL: begin
            dec_c.a_sel = A_SEL_PC;
            dec_c.b_sel = B_SEL_IMM;
         end
         default: bad_c = 1'b1;
      endcase
      if (bad_c) begin
         dec_c.illegal   = 1'b1;
         dec_c.alu_ctl   = ALU_ADD;
         dec_c.rd        = '0;
         dec_c.is_branch = 1'b0;
      end
   end

   assign bus.in_ready = (state_q == EMPTY) || bus.out_ready;
   assign accept_c     = bus.in_valid && bus.in_ready && !bus.flush;
   assign consume_c    = (state_q == FULL) && bus.out_ready;

   // Flush beats accept; accept-with-consume keeps FULL with the new bundle
   always_comb begin : next_state
      state_d  = state_q;
      bundle_d = bundle_q;
      if (bus.flush) begin
         state_d = EMPTY;
      end else if (accept_c) begin
         state_d  = FULL;
         bundle_d = dec_c;
      end else if (consume_c) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin : regs
      if (rst) begin
         state_q  <= EMPTY;
         bundle_q <= '0;
      end else begin
         state_q  <= state_d;
         bundle_q <= bundle_d;
      end
   end

   assign bus.out_valid = (state_q == FULL);
   assign bus.alu_ctl   = bundle_q.alu_ctl;
   assign bus.a_sel     = bundle_q.a_sel;
   assign bus.b_sel     = bundle_q.b_sel;
   assign bus.imm       = bundle_q.imm;
   assign bus.rs1       = bundle_q.rs1;
   assign bus.rs2       = bundle_q.rs2;
   assign bus.rd        = bundle_q.rd;
   assign bus.is_branch = bundle_q.is_branch;
   assign bus.illegal   = bundle_q.illegal;
   assign bus.pc_out    = bundle_q.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: expected bundles queued at drive time,
// compared in order against bundles observed leaving on the EX handshake.
module tb_alu_decode_stage;
   import alu_decode_stage_pkg::*;

   typedef struct packed {
      dec_bundle_t b;
      dec_bundle_t m;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   int unsigned cyc         = 0;
   exp_t        exp_q[$];
   dec_bundle_t obs_q[$];

   alu_decode_stage_if bus ();

   alu_decode_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // chk = {sel/is_branch, imm, rs1, rs2}; unchecked fields are don't-care
   function automatic exp_t mk(input alu_op_e alu, input logic [1:0] a, input logic bs,
                               input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic br, input logic ill,
                               input logic [3:0] chk);
      exp_t e;
      e.b           = '0;
      e.b.alu_ctl   = alu;
      e.b.a_sel     = a;
      e.b.b_sel     = bs;
      e.b.imm       = imm;
      e.b.rs1       = rs1;
      e.b.rs2       = rs2;
      e.b.rd        = rd;
      e.b.is_branch = br;
      e.b.illegal   = ill;
      e.m           = '1;
      if (!chk[3]) begin
         e.m.a_sel     = '0;
         e.m.b_sel     = '0;
         e.m.is_branch = '0;
      end
      if (!chk[2]) e.m.imm = '0;
      if (!chk[1]) e.m.rs1 = '0;
      if (!chk[0]) e.m.rs2 = '0;
      return e;
   endfunction

   function automatic dec_bundle_t sample();
      dec_bundle_t s;
      s.alu_ctl   = bus.alu_ctl;
      s.a_sel     = bus.a_sel;
      s.b_sel     = bus.b_sel;
      s.imm       = bus.imm;
      s.rs1       = bus.rs1;
      s.rs2       = bus.rs2;
      s.rd        = bus.rd;
      s.is_branch = bus.is_branch;
      s.illegal   = bus.illegal;
      s.pc        = bus.pc_out;
      return s;
   endfunction

   // One clock: capture a handshaken bundle at negedge, return at posedge+1
   task automatic cycle();
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) obs_q.push_back(sample());
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input exp_t e, input logic [31:0] instr, input logic [31:0] pc);
      int unsigned guard;
      e.b.pc       = pc;
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc    = pc;
      exp_q.push_back(e);
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 20) begin
         cycle();
         guard++;
      end
      if (guard >= 20) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: in_ready stuck at %b for instr %h", bus.in_ready, instr);
      end
      cycle();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      dec_bundle_t o;
      repeat (3) cycle();
      o = sample();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      end
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      vectors++;
      if (o !== '0) begin
         miscompares++;
         $display("FAIL reset_payload: got %h want 0", o);
      end
      rst = 1'b0;
      cycle();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release_valid: got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_decode();
      dec_bundle_t o;
      exp_t        e;
      bus.out_ready = 1'b1;
      send(mk(ALU_ADD,  A_SEL_RS1,  B_SEL_RS2, 32'h0,        5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 4'b1011), 32'h002081B3, 32'h100);
      send(mk(ALU_SUB,  A_SEL_RS1,  B_SEL_RS2, 32'h0,        5'd6, 5'd7, 5'd5, 1'b0, 1'b0, 4'b1011), 32'h407302B3, 32'h104);
      send(mk(ALU_SRA,  A_SEL_RS1,  B_SEL_IMM, 32'h3,        5'd2, 5'd0, 5'd1, 1'b0, 1'b0, 4'b1110), 32'h40315093, 32'h108);
      send(mk(ALU_EQ,   A_SEL_RS1,  B_SEL_RS2, 32'h8,        5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 4'b1111), 32'h00208463, 32'h10C);
      send(mk(ALU_ADD,  A_SEL_RS1,  B_SEL_IMM, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 4'b1110), 32'hFFF00093, 32'h110);
      send(mk(ALU_ADD,  A_SEL_ZERO, B_SEL_IMM, 32'h12345000, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 4'b1100), 32'h123450B7, 32'h114);
      send(mk(ALU_ADD,  A_SEL_RS1,  B_SEL_RS2, 32'h0,        5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b0000), 32'h00000000, 32'h118);
      send(mk(ALU_ADD,  A_SEL_RS1,  B_SEL_IMM, 32'h8,        5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 4'b1111), 32'h0020A423, 32'h11C);
      send(mk(ALU_ADD,  A_SEL_PC,   B_SEL_IMM, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 4'b1100), 32'hFFDFF0EF, 32'h120);
      send(mk(ALU_ADD,  A_SEL_PC,   B_SEL_IMM, 32'h00001000, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 4'b1100), 32'h00001297, 32'h124);
      send(mk(ALU_OR,   A_SEL_RS1,  B_SEL_RS2, 32'h0,        5'd5, 5'd6, 5'd4, 1'b0, 1'b0, 4'b1011), 32'h0062E233, 32'h128);
      send(mk(ALU_SLTU, A_SEL_RS1,  B_SEL_RS2, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 4'b1111), 32'hFE20EEE3, 32'h12C);
      send(mk(ALU_ADD,  A_SEL_RS1,  B_SEL_RS2, 32'h0,        5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b0000), 32'h022081B3, 32'h130);
      send(mk(ALU_ADD,  A_SEL_RS1,  B_SEL_RS2, 32'h0,        5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b0000), 32'h40109093, 32'h134);
      send(mk(ALU_ADD,  A_SEL_RS1,  B_SEL_RS2, 32'h0,        5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b0000), 32'h0020A463, 32'h138);
      repeat (2) cycle();
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL decode_count: got %0d bundles want %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         vectors++;
         if ((o & e.m) !== (e.b & e.m)) begin
            miscompares++;
            $display("FAIL decode_bundle pc=%h: got %h want %h mask %h", e.b.pc, o, e.b, e.m);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_hold_back_to_back();
      exp_t        ea;
      exp_t        eb;
      exp_t        e;
      dec_bundle_t o;
      int unsigned t0;
      ea = mk(ALU_ADD, A_SEL_RS1, B_SEL_RS2, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 4'b1011);
      eb = mk(ALU_SUB, A_SEL_RS1, B_SEL_RS2, 32'h0, 5'd6, 5'd7, 5'd5, 1'b0, 1'b0, 4'b1011);
      bus.out_ready = 1'b0;
      send(ea, 32'h002081B3, 32'h200);
      ea.b.pc      = 32'h200;
      eb.b.pc      = 32'h204;
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h407302B3;
      bus.in_pc    = 32'h204;
      exp_q.push_back(eb);
      for (int k = 0; k < 3; k++) begin
         o = sample();
         vectors++;
         if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_in_ready cycle %0d: got %b want 0", k, bus.in_ready);
         end
         vectors++;
         if (bus.out_valid !== 1'b1 || (o & ea.m) !== (ea.b & ea.m)) begin
            miscompares++;
            $display("FAIL hold_stable cycle %0d: valid %b got %h want %h", k, bus.out_valid, o, ea.b);
         end
         cycle();
      end
      bus.out_ready = 1'b1;
      cycle();
      t0 = cyc;
      send(mk(ALU_OR,  A_SEL_RS1, B_SEL_RS2, 32'h0,        5'd5, 5'd6, 5'd4, 1'b0, 1'b0, 4'b1011), 32'h0062E233, 32'h208);
      send(mk(ALU_EQ,  A_SEL_RS1, B_SEL_RS2, 32'h8,        5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 4'b1111), 32'h00208463, 32'h20C);
      send(mk(ALU_ADD, A_SEL_RS1, B_SEL_IMM, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 4'b1110), 32'hFFF00093, 32'h210);
      vectors++;
      if (cyc - t0 != 3) begin
         miscompares++;
         $display("FAIL back_to_back_cycles: got %0d cycles want 3", cyc - t0);
      end
      repeat (2) cycle();
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d bundles want %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         vectors++;
         if ((o & e.m) !== (e.b & e.m)) begin
            miscompares++;
            $display("FAIL b2b_bundle pc=%h: got %h want %h mask %h", e.b.pc, o, e.b, e.m);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      send(mk(ALU_ADD, A_SEL_RS1, B_SEL_IMM, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 4'b1110), 32'hFFF00093, 32'h300);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h002081B3;
      bus.in_pc    = 32'h304;
      bus.flush    = 1'b1;
      cycle();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_full: out_valid got %b want 0", bus.out_valid);
      end
      exp_q.delete();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.flush     = 1'b1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_empty_ready: in_ready got %b want 1", bus.in_ready);
      end
      cycle();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_no_accept: out_valid got %b want 0", bus.out_valid);
      end
      cycle();
      vectors++;
      if (bus.out_valid !== 1'b0 || obs_q.size() != 0) begin
         miscompares++;
         $display("FAIL flush_drop: out_valid %b, %0d bundles leaked want 0", bus.out_valid, obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_reset_mid_hold();
      dec_bundle_t o;
      bus.out_ready = 1'b0;
      send(mk(ALU_ADD, A_SEL_ZERO, B_SEL_IMM, 32'h12345000, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 4'b1100), 32'h123450B7, 32'h400);
      rst = 1'b1;
      cycle();
      o = sample();
      vectors++;
      if (bus.out_valid !== 1'b0 || o !== '0) begin
         miscompares++;
         $display("FAIL rst_mid_hold: valid %b payload %h want 0 and 0", bus.out_valid, o);
      end
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_hold_ready: got %b want 1", bus.in_ready);
      end
      rst = 1'b0;
      exp_q.delete();
      cycle();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_release_valid: got %b want 0", bus.out_valid);
      end
   endtask

   initial begin : main
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_decode();
      test_hold_back_to_back();
      test_flush();
      test_reset_mid_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
